rng_note_scheduler: RTL and testbench
=====================================

# rng_note_scheduler

Beat-driven scheduler that turns the free-running random stream (16-bit LFSR word plus 6-bit note) into note events for a bank of synthesizer voices. On every tempo beat it samples the random sources and decides between a rest and a note. For a note it derives a duration, picks a free voice round-robin and hands the event to the voice bank over a valid/ready handshake. It sits between the random-number generator and the voice/oscillator bank.

## Interface
- NUM_VOICES, 4, number of voices scheduled; power of two, 2..8
- DROP_W, 8, width of the saturating drop counter
- clk  in  1  system clock
- nrst  in  1  reset, asynchronous, active-low
- en  in  1  scheduler enable; low freezes beat counter and voice timers
- beat_len  in  16  clock cycles per beat; 0 is treated as 1
- rng_out  in  16  LFSR word from the random generator
- rng_note  in  6  random note index from the random generator
- evt_valid  out  1  note event pending
- evt_ready  in  1  voice bank accepts the event
- evt_voice  out  $clog2(NUM_VOICES)  target voice of the pending event
- evt_note  out  6  note index of the pending event
- voice_on  out  NUM_VOICES  per-voice sounding flag
- voice_note  out  NUM_VOICES×6  per-voice current note
- drop_cnt  out  DROP_W  beats lost (no free voice, or beat overrun); saturates

## Operation
- Beat counter:
  - While en=1, counts 0..max(beat_len,1)-1 and wraps.
  - beat_len is re-sampled at each wrap.
  - The beat pulse is the cycle in which the count equals the terminal value.
  - en=0 holds the count at 0.
- Capture: on a beat pulse, rng_out and rng_note are registered.
  - dur = rng_out[2:0]+1, giving 1..8 beats.
  - rest = (rng_out[15:14]==2'b00).
- FSM states IDLE, PICK, ISSUE:
  - IDLE→PICK on a beat pulse.
  - PICK with rest → IDLE. A rest is not counted as a drop.
  - PICK with no free voice → IDLE, drop_cnt++.
  - PICK with a free voice → ISSUE. The voice is the first with voice_on=0, searching upward from rr_ptr with wrap.
  - ISSUE holds evt_valid=1 with evt_voice and evt_note stable until evt_ready=1.
  - On the ISSUE handshake: voice_on[v]=1, voice_note[v]=note, timer[v]=dur, rr_ptr=v+1 mod NUM_VOICES, then → IDLE (or PICK if a beat is pending).
- Pending beat:
  - A beat arriving in PICK or ISSUE sets a 1-deep pending flag and captures fresh rng values.
  - A beat arriving while the flag is already set increments drop_cnt and overwrites the capture.
- Voice timers:
  - Each active timer decrements on every beat pulse.
  - At 0 the timer clears voice_on. voice_note holds its last value.
  - A timer loaded in the same cycle as a beat pulse is not decremented that cycle.
- en=0:
  - An in-flight ISSUE completes its handshake.
  - No new beats are generated; timers freeze.
- drop_cnt saturates at 2^DROP_W-1.

## Timing
- Reset values:
  - evt_valid=0, evt_voice=0, evt_note=0.
  - voice_on=0, voice_note=0, drop_cnt=0.
  - rr_ptr=0, all timers 0, pending=0, beat count 0, state IDLE.
- Latency: beat pulse in cycle T → PICK in T+1 → evt_valid=1 from T+2. With evt_ready already high, the handshake completes in T+2 and voice_on rises in T+3.
- Voice release: a voice freed by the beat in cycle T is visible to the PICK in T+1, so it is eligible for that beat's allocation.
- Handshake: evt_valid never drops without evt_ready. Outputs are registered, with no combinational path from evt_ready to evt_valid.
- Asynchronous reset mid-ISSUE: evt_valid drops immediately and the event is discarded.

## Structure
- Package synth_pkg holds:
  - the state enum sched_state_t {IDLE, PICK, ISSUE};
  - DUR_W=3;
  - the rest pattern REST_BITS=2'b00;
  - the note width NOTE_W=6.
- Sub-module voice_timer, one per voice:
  - inputs load, dur, beat, en;
  - outputs active and its countdown register.
- The round-robin free-voice search stays in the top module.

## Test plan
- Basic note: beat_len=4, rng_out=16'hC003, rng_note=6'd17, evt_ready=1 → evt_valid 2 cycles after the beat with evt_voice=0, evt_note=17; voice_on[0] stays high for 4 beats (16 cycles).
- Rest: rng_out=16'h0005 on a beat → no evt_valid, drop_cnt unchanged, rr_ptr unchanged.
- Round-robin and exhaustion: 5 consecutive beats, each with rng_out=16'hFFFF (dur 8) → voices 0,1,2,3 issued in order; the 5th beat gives drop_cnt=1.
- Backpressure: evt_ready=0 for 10 cycles with beat_len=3 → evt_valid and its fields held stable; one pending beat is kept; further beats give drop_cnt=2; on release the pending beat issues to voice 1.
- Boundary: beat_len=0 → a beat every cycle; dur=1 voice released on the next beat and reallocated in the same PICK; a timer load coinciding with a beat is not decremented.
- Reset and enable: assert nrst low during ISSUE → all outputs at reset values asynchronously. en=0 for 20 cycles → no beats and timers frozen; the countdown resumes exactly on re-enable.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared types and constants for the beat-driven note scheduler.
// Imported by the scheduler top and its per-voice timers.
package synth_pkg;
  typedef enum logic [1:0] {IDLE, PICK, ISSUE} sched_state_t;
  localparam int DUR_W = 3;
  localparam logic [1:0] REST_BITS = 2'b00;
  localparam int NOTE_W = 6;
endpackage

// File: rtl/voice_timer.sv
// Per-voice beat countdown; the voice sounds while the count is non-zero.
// A load wins over a coincident beat so a fresh note keeps its full length.
module voice_timer
  import synth_pkg::*;
(
  input  logic           clk,
  input  logic           nrst,
  input  logic           en,
  input  logic           beat,
  input  logic           load,
  input  logic [DUR_W:0] dur,
  output logic           active,
  output logic [DUR_W:0] count
);

  localparam logic [DUR_W:0] ONE = 1;

  logic [DUR_W:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = dur;
    end else if (beat && en && cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign active = (cnt_q != '0);
  assign count  = cnt_q;

endmodule

// File: rtl/rng_note_scheduler.sv
// Turns the random stream into note events on each tempo beat and
// hands them round-robin to free voices over a valid/ready handshake.
module rng_note_scheduler
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int DROP_W     = 8
)(
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         en,
  input  logic [15:0]                  beat_len,
  input  logic [15:0]                  rng_out,
  input  logic [NOTE_W-1:0]            rng_note,
  output logic                         evt_valid,
  input  logic                         evt_ready,
  output logic [$clog2(NUM_VOICES)-1:0] evt_voice,
  output logic [NOTE_W-1:0]            evt_note,
  output logic [NUM_VOICES-1:0]        voice_on,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [DROP_W-1:0]            drop_cnt
);

  localparam int VW = $clog2(NUM_VOICES);
  typedef logic [VW-1:0] vidx_t;

  logic [15:0] cnt_q, cnt_d, len_q, len_cur;
  logic        beat;

  sched_state_t      state_q, state_d;
  logic              pend_q, pend_d;
  logic              drop_inc, ev_set, hs, rest, free_ok;
  logic [15:0]       rng_q;
  logic [NOTE_W-1:0] note_q;
  logic [DUR_W:0]    dur, edur_q;
  vidx_t             free_v, rr_q;
  logic              evt_valid_q;
  vidx_t             evt_voice_q;
  logic [NOTE_W-1:0] evt_note_q;
  logic [DROP_W-1:0] drop_q;
  logic [NOTE_W-1:0] vnote_q [NUM_VOICES];
  logic [DUR_W:0]    tcnt [NUM_VOICES];
  logic [NUM_VOICES-1:0] von, load;
  logic              unused_rng;

  // Beat length is latched at the start of each period.
  always_comb begin
    len_cur = len_q;
    if (cnt_q == '0) len_cur = (beat_len == '0) ? 16'd1 : beat_len;
    beat  = en && (cnt_q == len_cur - 16'd1);
    cnt_d = '0;
    if (en && !beat) cnt_d = cnt_q + 16'd1;
  end

  assign dur  = {1'b0, rng_q[DUR_W-1:0]} + {{DUR_W{1'b0}}, 1'b1};
  assign rest = (rng_q[15:14] == REST_BITS);
  assign hs   = (state_q == ISSUE) && evt_ready;
  assign unused_rng = ^rng_q[13:DUR_W];

  // Lowest offset from rr_q wins, so scan downward.
  always_comb begin
    free_ok = 1'b0;
    free_v  = rr_q;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (tcnt[rr_q + vidx_t'(i)] == '0) begin
        free_ok = 1'b1;
        free_v  = rr_q + vidx_t'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    drop_inc = 1'b0;
    ev_set   = 1'b0;
    unique case (state_q)
      IDLE: if (beat) state_d = PICK;
      PICK: begin
        if (!rest && free_ok) begin
          state_d = ISSUE;
          ev_set  = 1'b1;
          if (beat) pend_d = 1'b1;
        end else begin
          if (!rest) drop_inc = 1'b1;
          state_d = beat ? PICK : IDLE;
        end
      end
      ISSUE: begin
        if (evt_ready) begin
          state_d = (beat || pend_q) ? PICK : IDLE;
          pend_d  = 1'b0;
          if (beat && pend_q) drop_inc = 1'b1;
        end else if (beat) begin
          pend_d = 1'b1;
          if (pend_q) drop_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q       <= '0;
      len_q       <= 16'd1;
      state_q     <= IDLE;
      pend_q      <= 1'b0;
      rng_q       <= '0;
      note_q      <= '0;
      evt_valid_q <= 1'b0;
      evt_voice_q <= '0;
      evt_note_q  <= '0;
      edur_q      <= '0;
      rr_q        <= '0;
      drop_q      <= '0;
      for (int v = 0; v < NUM_VOICES; v++) vnote_q[v] <= '0;
    end else begin
      cnt_q   <= cnt_d;
      len_q   <= len_cur;
      state_q <= state_d;
      pend_q  <= pend_d;
      if (beat) begin
        rng_q  <= rng_out;
        note_q <= rng_note;
      end
      if (ev_set) begin
        evt_valid_q <= 1'b1;
        evt_voice_q <= free_v;
        evt_note_q  <= note_q;
        edur_q      <= dur;
      end else if (hs) begin
        evt_valid_q <= 1'b0;
      end
      if (hs) begin
        rr_q <= evt_voice_q + vidx_t'(1);
        vnote_q[evt_voice_q] <= evt_note_q;
      end
      if (drop_inc && drop_q != '1) drop_q <= drop_q + DROP_W'(1);
    end
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    assign load[v] = hs && (evt_voice_q == vidx_t'(v));
    voice_timer u_tmr (
      .clk   (clk),
      .nrst  (nrst),
      .en    (en),
      .beat  (beat),
      .load  (load[v]),
      .dur   (edur_q),
      .active(von[v]),
      .count (tcnt[v])
    );
    assign voice_note[v*NOTE_W +: NOTE_W] = vnote_q[v];
  end

  assign evt_valid = evt_valid_q;
  assign evt_voice = evt_voice_q;
  assign evt_note  = evt_note_q;
  assign voice_on  = von;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_rng_note_scheduler.sv
// Bench for rng_note_scheduler: table of beats, hand-built corner cases,
// and a random run against a queue-based reference model.
module tb_rng_note_scheduler;
  localparam int NV = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic en = 1'b0;
  logic evt_ready = 1'b0;
  logic [15:0] beat_len = 16'd4;
  logic [15:0] rng_out = 16'h0;
  logic [5:0] rng_note = 6'd0;
  logic evt_valid;
  logic [1:0] evt_voice;
  logic [5:0] evt_note;
  logic [NV-1:0] voice_on;
  logic [NV*6-1:0] voice_note;
  logic [DW-1:0] drop_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rng_note_scheduler #(.NUM_VOICES(NV), .DROP_W(DW)) dut (
    .clk(clk), .nrst(nrst), .en(en), .beat_len(beat_len),
    .rng_out(rng_out), .rng_note(rng_note),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_voice(evt_voice), .evt_note(evt_note),
    .voice_on(voice_on), .voice_note(voice_note), .drop_cnt(drop_cnt)
  );

  typedef struct { logic [15:0] w; logic [5:0] n; } cap_t;
  int   m_elapsed, m_len, m_rr, m_voice, m_note, m_dur, m_drop;
  int   m_left [NV];
  int   m_vnote [NV];
  bit   m_valid, m_decide;
  cap_t m_cap;
  cap_t waitq [$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_elapsed = 0; m_len = 1; m_rr = 0; m_voice = 0; m_note = 0;
    m_dur = 0; m_drop = 0; m_valid = 0; m_decide = 0;
    m_cap = '{16'h0, 6'd0};
    waitq.delete();
    for (int v = 0; v < NV; v++) begin m_left[v] = 0; m_vnote[v] = 0; end
  endtask

  task automatic bump_drop();
    if (m_drop < (1 << DW) - 1) m_drop++;
  endtask

  // One clock of the reference behaviour, from the inputs seen at the edge.
  task automatic model_step();
    int lenn, found;
    bit beat, hs, issue;
    cap_t fresh;
    lenn = (m_elapsed == 0) ? ((beat_len == 0) ? 1 : int'(beat_len)) : m_len;
    beat = en && (m_elapsed + 1 == lenn);
    m_len = lenn;
    m_elapsed = (!en || beat) ? 0 : m_elapsed + 1;
    hs = m_valid && evt_ready;
    issue = 0;
    found = -1;
    if (m_decide && m_cap.w[15:14] != 2'b00) begin
      for (int k = 0; k < NV; k++)
        if (found < 0 && m_left[(m_rr + k) % NV] == 0) found = (m_rr + k) % NV;
      if (found < 0) bump_drop();
      else issue = 1;
    end
    for (int v = 0; v < NV; v++) begin
      if (hs && v == m_voice) m_left[v] = m_dur;
      else if (beat && m_left[v] > 0) m_left[v]--;
    end
    if (hs) begin
      m_rr = (m_voice + 1) % NV;
      m_vnote[m_voice] = m_note;
      m_valid = 0;
    end
    if (issue) begin
      m_valid = 1;
      m_voice = found;
      m_note = int'(m_cap.n);
      m_dur = int'(m_cap.w[2:0]) + 1;
    end
    fresh.w = rng_out;
    fresh.n = rng_note;
    m_decide = 0;
    if (beat) begin
      if (waitq.size() > 0) begin
        bump_drop();
        void'(waitq.pop_front());
      end
      if (m_valid) waitq.push_back(fresh);
      else begin m_decide = 1; m_cap = fresh; end
    end else if (!m_valid && waitq.size() > 0) begin
      m_cap = waitq.pop_front();
      m_decide = 1;
    end
  endtask

  task automatic cmp_all();
    logic [NV-1:0] eon;
    logic [NV*6-1:0] enote;
    for (int v = 0; v < NV; v++) begin
      eon[v] = (m_left[v] > 0);
      enote[v*6 +: 6] = m_vnote[v][5:0];
    end
    chk("m_evt_valid", evt_valid, m_valid);
    chk("m_evt_voice", evt_voice, m_voice);
    chk("m_evt_note", evt_note, m_note);
    chk("m_voice_on", voice_on, eon);
    chk("m_voice_note", voice_note, enote);
    chk("m_drop_cnt", drop_cnt, m_drop);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cmp_all();
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    model_reset();
    #1;
    cmp_all();
    #1;
    nrst = 1'b1;
  endtask

  typedef struct {
    logic [15:0] w; logic [5:0] n; bit v; int voice; int drop; logic [3:0] on;
  } vec_t;
  vec_t tbl [8];
  logic [15:0] seq_w [5];

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{16'hC003, 6'd17, 1'b1, 0, 0, 4'b0001};
    tbl[1] = '{16'h0005, 6'd9,  1'b0, 0, 0, 4'b0001};
    tbl[2] = '{16'hFFFF, 6'd20, 1'b1, 1, 0, 4'b0011};
    tbl[3] = '{16'hFFFF, 6'd21, 1'b1, 2, 0, 4'b0111};
    tbl[4] = '{16'hFFFF, 6'd22, 1'b1, 3, 0, 4'b1110};
    tbl[5] = '{16'hFFFF, 6'd23, 1'b1, 0, 0, 4'b1111};
    tbl[6] = '{16'hFFFF, 6'd24, 1'b0, 0, 1, 4'b1111};
    tbl[7] = '{16'h0005, 6'd25, 1'b0, 0, 1, 4'b1111};

    // Table: one beat every 4 cycles, the beat lands on each record's first tick.
    en = 1; beat_len = 4; evt_ready = 1; rng_out = 16'h0005;
    do_reset();
    chk("rst_valid", evt_valid, 0);
    chk("rst_drop", drop_cnt, 0);
    repeat (3) tick();
    for (int k = 0; k < 8; k++) begin
      rng_out = tbl[k].w; rng_note = tbl[k].n;
      tick();
      rng_out = 16'h0005;
      tick();
      chk("tbl_valid", evt_valid, tbl[k].v);
      if (tbl[k].v) begin
        chk("tbl_voice", evt_voice, tbl[k].voice);
        chk("tbl_note", evt_note, tbl[k].n);
      end
      tick(); tick();
      chk("tbl_drop", drop_cnt, tbl[k].drop);
      chk("tbl_on", voice_on, tbl[k].on);
    end

    // Backpressure with beat_len=3.
    evt_ready = 0; beat_len = 3; rng_out = 16'hFFFF; rng_note = 6'd5;
    do_reset();
    repeat (4) tick();
    chk("bp_valid", evt_valid, 1);
    chk("bp_voice", evt_voice, 0);
    chk("bp_note", evt_note, 5);
    rng_note = 6'd11;
    repeat (9) begin
      tick();
      chk("bp_hold_valid", evt_valid, 1);
      chk("bp_hold_voice", evt_voice, 0);
      chk("bp_hold_note", evt_note, 5);
    end
    chk("bp_drop", drop_cnt, 2);
    evt_ready = 1;
    tick();
    chk("bp_hs_on", voice_on, 4'b0001);
    tick();
    chk("bp_rel_valid", evt_valid, 1);
    chk("bp_rel_voice", evt_voice, 1);
    chk("bp_rel_note", evt_note, 11);

    // beat_len=0: a beat every cycle, dur=1 notes.
    evt_ready = 1; beat_len = 0; rng_out = 16'h4000; rng_note = 6'd2;
    do_reset();
    repeat (3) tick();
    chk("b0_load_on", voice_on[0], 1);
    chk("b0_drop", drop_cnt, 1);
    tick();
    chk("b0_release", voice_on[0], 0);

    // A voice released by a beat is reusable by that beat's own pick.
    seq_w = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h4000, 16'hFFFF};
    beat_len = 4; evt_ready = 1; rng_note = 6'd7;
    do_reset();
    for (int j = 0; j < 5; j++) begin
      rng_out = seq_w[j];
      repeat (4) tick();
    end
    tick();
    chk("realloc_valid", evt_valid, 1);
    chk("realloc_voice", evt_voice, 3);
    chk("realloc_drop", drop_cnt, 0);

    // Asynchronous reset while an event waits for ready.
    beat_len = 2; evt_ready = 1; rng_out = 16'hC003; rng_note = 6'd17;
    do_reset();
    repeat (4) tick();
    evt_ready = 0;
    tick();
    chk("ar_valid", evt_valid, 1);
    chk("ar_voice", evt_voice, 1);
    chk("ar_on", voice_on, 4'b0001);
    #2;
    nrst = 0;
    #1;
    model_reset();
    chk("ar_rst_valid", evt_valid, 0);
    chk("ar_rst_voice", evt_voice, 0);
    chk("ar_rst_on", voice_on, 0);
    chk("ar_rst_vnote", voice_note, 0);
    cmp_all();
    #1;
    nrst = 1;

    // Enable low freezes beats and timers.
    beat_len = 4; evt_ready = 1; rng_out = 16'hC003; rng_note = 6'd3;
    do_reset();
    repeat (6) tick();
    rng_out = 16'h0005;
    repeat (3) tick();
    chk("en_pre_on", voice_on, 4'b0001);
    en = 0;
    repeat (20) begin
      tick();
      chk("en0_valid", evt_valid, 0);
      chk("en0_on", voice_on, 4'b0001);
    end
    en = 1;
    repeat (11) tick();
    chk("en_resume_on", voice_on[0], 1);
    tick();
    chk("en_resume_off", voice_on[0], 0);

    // Saturating drop counter.
    beat_len = 0; evt_ready = 0; rng_out = 16'hFFFF;
    do_reset();
    repeat (300) tick();
    chk("drop_sat", drop_cnt, 255);

    // Random traffic against the model.
    en = 1; evt_ready = 1; beat_len = 3;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 40 == 0) beat_len = 16'($urandom_range(0, 6));
      en = ($urandom_range(0, 15) != 0);
      evt_ready = ($urandom_range(0, 2) != 0);
      rng_out = 16'($urandom);
      rng_note = 6'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
